// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_debounce                                                  |
// | Brief    : N-channel key synchroniser/debouncer with press/release pulses |
// |            and lowest-index key code. Auto-repeat: KEY_DEBOUNCE_REPEAT_EN |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_KEYS-1:0]         key,
  output logic [N_KEYS-1:0]         pressed,
  output logic [N_KEYS-1:0]         press_pulse,
  output logic [N_KEYS-1:0]         release_pulse,
  output logic                      button_down,
  output logic [$clog2(N_KEYS)-1:0] key_code
);

  localparam int c_code_w = $clog2(N_KEYS);
  localparam int c_cnt_w  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int c_rpt_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_rpt_w   = $clog2(c_rpt_max + 1);
  localparam logic [c_rpt_w-1:0] c_rpt_delay_m1  = c_rpt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_rpt_period_m1 = c_rpt_w'(REPEAT_PERIOD - 1);
`endif

  if (N_KEYS < 2 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_debounce: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_KEYS-1:0]   w_s;
  logic [c_code_w-1:0] w_key_code;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_pressed;
    logic                   r_press_pulse;
    logic                   r_release_pulse;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    logic [c_rpt_w-1:0]     r_rpt;
    logic                   r_rpt_armed;
`endif

    // Raw key is active-low, so the flops reset to 1 (released).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '1;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], key[gi]};
    end

    assign w_s[gi] = ~r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state         <= S_IDLE;
        r_cnt           <= '0;
        r_pressed       <= 1'b0;
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        r_rpt           <= '0;
        r_rpt_armed     <= 1'b0;
`endif
      end else begin
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_s[gi]) begin
              r_state <= S_PRESS_WAIT;
              r_cnt   <= '0;
            end
          end
          S_PRESS_WAIT: begin
            if (!w_s[gi]) begin
              r_state <= S_IDLE;
            end else if (r_cnt == c_cnt_max) begin
              r_state       <= S_PRESSED;
              r_pressed     <= 1'b1;
              r_press_pulse <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
              r_rpt         <= '0;
              r_rpt_armed   <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_PRESSED: begin
            if (!w_s[gi]) begin
              r_state <= S_RELEASE_WAIT;
              r_cnt   <= '0;
            end
`ifdef KEY_DEBOUNCE_REPEAT_EN
            // First repeat after the long delay, then at the shorter period.
            else if (r_rpt == (r_rpt_armed ? c_rpt_period_m1 : c_rpt_delay_m1)) begin
              r_press_pulse <= 1'b1;
              r_rpt         <= '0;
              r_rpt_armed   <= 1'b1;
            end else begin
              r_rpt <= r_rpt + 1'b1;
            end
`endif
          end
          S_RELEASE_WAIT: begin
            if (w_s[gi]) begin
              r_state <= S_PRESSED;
            end else if (r_cnt == c_cnt_max) begin
              r_state         <= S_IDLE;
              r_pressed       <= 1'b0;
              r_release_pulse <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
              r_rpt           <= '0;
              r_rpt_armed     <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign pressed[gi]       = r_pressed;
    assign press_pulse[gi]   = r_press_pulse;
    assign release_pulse[gi] = r_release_pulse;
  end

  // Descending scan so the lowest pressed index wins.
  always_comb begin
    w_key_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pressed[i]) w_key_code = c_code_w'(i);
    end
  end

  assign key_code    = w_key_code;
  assign button_down = |pressed;

endmodule
`default_nettype wire
